// File: rtl/field_pkg.sv
// Curve25519 field constants and shared types.
// Provides the prime, field width and reducer state encoding.
package field_pkg;

  localparam int FE_W = 256;

  localparam logic [FE_W-1:0] P25519 =
    (256'd1 << 255) - 256'd19;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mod_p_if.sv
// Operand/result bundle for the mod_p reducer.
// master drives n and reads rem; slave is the reducer side.
interface mod_p_if;
  import field_pkg::*;

  logic [FE_W-1:0] n;
  logic [FE_W-1:0] rem;

  modport master (
    output n,
    input  rem
  );

  modport slave (
    input  n,
    output rem
  );

endinterface

// File: rtl/cond_sub_p.sv
// Combinational compare-and-subtract against p = 2^255-19.
// a: N+1-bit value; ge: a >= p; diff: a - p (meaningful when ge).
module cond_sub_p
  import field_pkg::*;
#(
  parameter int N = FE_W
) (
  input  logic [N:0] a,
  output logic       ge,
  output logic [N:0] diff
);

  localparam logic [N:0] P_EXT = {1'b0, P25519};

  assign ge   = (a >= P_EXT);
  assign diff = a - P_EXT;

endmodule

// File: rtl/mod_p.sv
// Sequential reducer: rem = n mod (2^255-19), captured once after reset.
// Ports: n operand, clk, rst_n async active-low, rem registered result.
module mod_p
  import field_pkg::*;
#(
  parameter int N = FE_W
) (
  input  logic [N-1:0] n,
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] rem
);

  state_e     state;
  logic [N:0] acc;
  logic       ge;
  logic [N:0] diff;

  cond_sub_p #(.N(N)) u_sub (
    .a    (acc),
    .ge   (ge),
    .diff (diff)
  );

  // rem is written only on the DONE transition, so no partial
  // value ever reaches the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      acc   <= '0;
      rem   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          acc   <= {1'b0, n};
          state <= REDUCE;
        end
        REDUCE: begin
          if (ge) begin
            acc <= diff;
          end else begin
            rem   <= acc[N-1:0];
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_p.sv
// Directed and random checks for the mod_p reducer.
// Vector table with latencies plus reset/hold sequences.
module tb_mod_p;
  import field_pkg::*;

  logic clk;
  logic rst_n;
  mod_p_if bus ();

  mod_p dut (
    .n     (bus.n),
    .clk   (clk),
    .rst_n (rst_n),
    .rem   (bus.rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [255:0] n;
    logic [255:0] exp;
    int           lat;
    string        name;
  } vec_t;

  vec_t tbl[10];

  localparam logic [255:0] ONES = '1;

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive n, pulse reset, verify rem cleared, release at negedge.
  task automatic start(input logic [255:0] v, input string name);
    @(negedge clk);
    bus.n = v;
    rst_n = 1'b0;
    #1;
    chk({name, "_rst"}, bus.rem, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Check rem each posedge: zero before lat, exp from lat on.
  task automatic run_vec(input vec_t v);
    start(v.n, v.name);
    for (int k = 1; k <= v.lat + 2; k++) begin
      @(posedge clk);
      #1;
      if (k < v.lat)
        chk($sformatf("%s_pe%0d", v.name, k), bus.rem, '0);
      else
        chk($sformatf("%s_pe%0d", v.name, k), bus.rem, v.exp);
    end
  endtask

  logic [255:0] rnd;
  logic [255:0] ref_r;
  logic [255:0] held;
  logic         stable;

  initial begin
    logic [255:0] p;
    p = P25519;
    tbl[0] = '{256'd5000000, 256'h4C4B40, 2, "n5m"};
    tbl[1] = '{ONES, 256'd37, 4, "ones"};
    tbl[2] = '{p, 256'd0, 3, "p"};
    tbl[3] = '{p - 256'd1, p - 256'd1, 2, "pm1"};
    tbl[4] = '{ONES - 256'd37, 256'd0, 4, "twop"};
    tbl[5] = '{ONES - 256'd38, p - 256'd1, 3, "twopm1"};
    tbl[6] = '{p + 256'd1, 256'd1, 3, "pp1"};
    tbl[7] = '{256'd1 << 255, 256'd19, 3, "pow255"};
    tbl[8] = '{256'd0, 256'd0, 2, "zero"};
    tbl[9] = '{ONES - 256'd36, 256'd1, 4, "twopp1"};

    rst_n = 1'b0;
    bus.n = 256'd5000000;

    // Long reset with clocks running: rem must stay 0.
    stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.rem !== '0) stable = 1'b0;
    end
    chk("hold_rst", {255'd0, stable}, 256'd1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // First vector again, then 100 us of stability.
    run_vec(tbl[0]);
    stable = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clk);
      #1;
      if (bus.rem !== 256'h4C4B40) stable = 1'b0;
    end
    chk("stable_100us", {255'd0, stable}, 256'd1);

    // n changes after DONE must be ignored.
    run_vec(tbl[1]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.n = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk($sformatf("ign_n%0d", k), bus.rem, 256'd37);
    end

    // Async reset after DONE clears rem between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_done", bus.rem, '0);
    @(negedge clk);

    // Async reset mid-REDUCE, then restart with n=7.
    bus.n = ONES;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mid", bus.rem, '0);
    @(posedge clk);
    #1;
    chk("mid_held", bus.rem, '0);
    run_vec('{256'd7, 256'd7, 2, "seven"});

    // Random operands, half forced into the top range.
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      if (i[0]) rnd[255:250] = 6'h3F;
      ref_r = rnd % P25519;
      start(rnd, "rnd");
      repeat (5) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d", i), bus.rem, ref_r);
      chk($sformatf("rnd%0d_ltp", i),
          {255'd0, (bus.rem < P25519)}, 256'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
